// File: rtl/rr_mux_arb.sv
// N-channel valid/ready arbiter with fixed-priority or round-robin selection,
// registering the winning word into a single output stage.
module rr_mux_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_ready
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;

  logic            load_en;
  logic            found;
  logic            xfer;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W-1:0] cand;

  // Search order starts at ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    found    = 1'b0;
    grant_ch = '0;
    cand     = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (mode) begin
        cand = CH_W'((32'(ptr_q) + j) % NUM_CH);
      end else begin
        cand = CH_W'(j);
      end
      if (!found && in_valid[cand]) begin
        found    = 1'b1;
        grant_ch = cand;
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  assign xfer    = load_en && found && rst_n;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_ch] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d = in_data[32'(grant_ch) * DATA_WIDTH +: DATA_WIDTH];
      out_ch_d   = grant_ch;
      if (mode) begin
        ptr_d = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Randomised bench for rr_mux_arb: a behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_mux_arb;

  localparam int unsigned DW     = 32;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mode;
  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_ready;

  int n_chk = 0;
  int n_err = 0;

  rr_mux_arb #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the word held by the output stage and the rotating pointer.
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_ptr;
  int            exp_g;
  logic [NUM_CH-1:0] exp_ready;

  function automatic int pick(input logic md, input logic [NUM_CH-1:0] v, input int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = md ? (ptr + k) % NUM_CH : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] data_of(input int c);
    return in_data[c*DW +: DW];
  endfunction

  always_comb begin
    exp_g     = pick(mode, in_valid, m_ptr);
    exp_ready = '0;
    if (rst_n && exp_g >= 0 && (!m_valid || out_ready)) exp_ready[exp_g] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_ptr   <= 0;
    end else if (exp_g >= 0 && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_data  <= data_of(exp_g);
      m_ch    <= exp_g;
      if (mode) m_ptr <= (exp_g + 1) % NUM_CH;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_data", 64'(out_data), 64'(m_data));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
  end

  task automatic set_data(input int c, input logic [DW-1:0] v);
    in_data[c*DW +: DW] = v;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mode      = 1'b0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) set_data(i, 32'hD0 + 32'(i));

    // Reset held with all channels requesting.
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    next();
    chk("rel_valid", 64'(out_valid), 64'd1);
    chk("rel_ch", 64'(out_ch), 64'd0);

    // Fixed priority: ch1 beats ch3.
    in_valid = 4'b1010;
    set_data(1, 32'h11);
    set_data(3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("prio_ready", 64'(in_ready), 64'b0010);
      next();
      chk("prio_data", 64'(out_data), 64'h11);
      chk("prio_ch", 64'(out_ch), 64'd1);
    end

    // Round robin with every channel requesting.
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) set_data(i, 32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      next();
      chk("rr_ch", 64'(out_ch), 64'(i % NUM_CH));
      chk("rr_data", 64'(out_data), 64'(32'hA0 + 32'(i % NUM_CH)));
    end

    // Wrap from ch3 to ptr=0, skip to ch2, then ch3 ahead of ch0.
    in_valid = 4'b1000;
    next();
    chk("wrap_ch3", 64'(out_ch), 64'd3);
    in_valid = 4'b0100;
    next();
    chk("skip_ch2", 64'(out_ch), 64'd2);
    in_valid = 4'b1001;
    @(negedge clk);
    chk("rr_ready", 64'(in_ready), 64'b1000);
    next();
    chk("ptr3_ch", 64'(out_ch), 64'd3);

    // Back-pressure holds the word; release reloads on the same edge.
    in_valid = 4'b0001;
    set_data(0, 32'h55);
    next();
    chk("bp_load", 64'(out_data), 64'h55);
    out_ready = 1'b0;
    set_data(0, 32'h66);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(in_ready), 64'd0);
      next();
      chk("bp_data", 64'(out_data), 64'h55);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready", 64'(in_ready), 64'b0001);
    next();
    chk("bp_rel_data", 64'(out_data), 64'h66);
    chk("bp_rel_valid", 64'(out_valid), 64'd1);

    // Drain to empty, then async reset in the middle of a stall.
    in_valid = '0;
    next();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data", 64'(out_data), 64'h66);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    next();
    chk("stall_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_data", 64'(out_data), 64'd0);
    chk("async_ch", 64'(out_ch), 64'd0);
    rst_n = 1'b1;

    // Random traffic, occasional mode flips and reset pulses.
    for (int n = 0; n < 3000; n++) begin
      next();
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      in_valid  = NUM_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) set_data(i, $urandom);
    end

    next();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel successor to the 2:1 datapath mux.
- Selects one of NUM_CH DATA_WIDTH-bit sources per cycle under valid/ready handshake, in fixed-priority or round-robin mode.
- Registers the winner into a single output stage.
- Used wherever several producers (ALU result, memory read data, immediate path) contend for one consumer, such as a write-back bus.

Parameters:
- DATA_WIDTH, 32, width of each data channel.
- NUM_CH, 4, number of input channels (2..16).
- CH_W, 2, width of channel index. Must equal ceil(log2(NUM_CH)), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin.
- in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_WIDTH  registered selected word.
- out_ch  output  CH_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): out_valid=0, out_data=0, out_ch=0, internal pointer ptr=0. in_ready is then 0 because no grant is possible while reset is held.
- load_en = !out_valid | out_ready. The output stage accepts a new word when it is empty or being drained in the same cycle.
- Grant (combinational):
  - mode=0: lowest-index i with in_valid[i]=1.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, … wrapping mod NUM_CH.
  - No grant if in_valid is all zero.
- in_ready[i] = load_en & grant[i]. At most one bit is set, and never a bit whose in_valid is 0.
- Transfer on channel k occurs when in_valid[k] & in_ready[k] at a clock edge. At that edge:
  - out_data <= channel k data
  - out_ch <= k
  - out_valid <= 1
- Drain without refill (out_valid & out_ready, no transfer) sets out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid & !out_ready): out_valid, out_data and out_ch hold. in_ready is all 0.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Sustains 1 word/cycle while out_ready=1.
  - Simultaneous drain and refill in the same cycle is a legal back-to-back transfer.
- Pointer:
  - In mode=1, after a transfer on k, ptr <= (k+1) mod NUM_CH. Wrap: k=NUM_CH-1 gives ptr=0.
  - In mode=0, ptr holds.
  - Switching mode takes effect on the next grant evaluation; no flush is required.
- Fairness: in mode=1 with all channels valid and out_ready=1, grants cycle 0,1,…,NUM_CH-1,0,…
- Single requester: it wins every load_en cycle in either mode.
- in_valid dropping before acceptance is tolerated. Grant re-evaluates every cycle, so there is no lock.
- in_ready may depend combinationally on out_ready and in_valid. out_valid, out_data and out_ch are purely registered.
- Reset asserted mid-stream discards the held word and returns ptr to 0. No transfer completes on the edge where rst_n is low.

Test Plan:
- Reset: rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release, next edge -> out_ch=0, out_valid=1.
- Priority: mode=0, in_valid=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1 for 3 cycles -> out_data=0x11 and out_ch=1 every cycle. in_ready=4'b0010 throughout.
- Round robin: mode=1, in_valid=4'b1111, data ch i=0xA0+i, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1. out_data matches 0xA0+out_ch.
- Wrap and skip: mode=1, transfer on ch3 (ptr->0), then in_valid=4'b0100 -> next grant ch2, ptr=3. Then in_valid=4'b1001 -> ch3 wins before ch0.
- Back-pressure: out_valid=1, out_data=0x55, out_ready=0 for 4 cycles with in_valid=4'b0001 -> out_data stays 0x55, in_ready=0. out_ready=1 -> same edge loads ch0 data, out_valid stays 1.
- Drain to empty: out_valid=1, in_valid=0, out_ready=1 -> out_valid=0 next edge, out_data unchanged. Async reset pulse mid-stall -> out_valid=0 without a clock edge.
